// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: length codes, FSM states, the latched
// request record, and the alignment / load-extension helpers.
package dmem_responder_pkg;

    localparam logic [1:0] MEM_LEN_NONE = 2'b00;
    localparam logic [1:0] MEM_LEN_BYTE = 2'b01;
    localparam logic [1:0] MEM_LEN_HALF = 2'b10;
    localparam logic [1:0] MEM_LEN_WORD = 2'b11;

    typedef enum logic [1:0] {
        DMEM_ST_IDLE = 2'b00,
        DMEM_ST_WAIT = 2'b01,
        DMEM_ST_RESP = 2'b10
    } dmem_state_e;

    typedef struct packed {
        logic        is_store;
        logic [1:0]  len;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] off);
        logic mis;
        case (len)
            MEM_LEN_HALF: mis = off[0];
            MEM_LEN_WORD: mis = (off != 2'b00);
            default:      mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                                 input logic [1:0] len, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (len)
            MEM_LEN_BYTE: r = {{24{sgn & b[7]}}, b};
            MEM_LEN_HALF: r = {{16{sgn & h[15]}}, h};
            default:      r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// Word-organised SRAM with a byte-enable synchronous write and a combinational read,
// so the responder can register extended load data on the same edge the access executes.
module dmem_sram_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Responder for the CPU data-memory interface: one load/store in flight, fixed wait
// states, little-endian lane steering, load extension and misalignment reporting.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset_n,
    input  logic        MEM_req_valid,
    output logic        MEM_req_ready,
    input  logic [1:0]  MEM_write_length,
    input  logic [1:0]  MEM_read_length,
    input  logic        MEM_read_signed,
    input  logic [31:0] MEM_write_address,
    input  logic [31:0] MEM_write_data,
    input  logic [31:0] MEM_read_address,
    output logic        MEM_resp_valid,
    output logic [31:0] MEM_read_data,
    output logic        MEM_misaligned
);

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;

    dmem_req_t   in_req, cur_req;
    logic        accept, exec, mis_now;
    logic [3:0]  sram_be;
    logic [31:0] sram_wdata, sram_rdata;
    logic        unused_addr_bits;

    always_comb begin
        in_req.is_store = (MEM_write_length != MEM_LEN_NONE);
        in_req.len      = in_req.is_store ? MEM_write_length :
                          (MEM_read_length == MEM_LEN_NONE) ? MEM_LEN_WORD : MEM_read_length;
        in_req.sgn      = MEM_read_signed;
        in_req.addr     = in_req.is_store ? MEM_write_address : MEM_read_address;
        in_req.wdata    = MEM_write_data;
    end

    // In IDLE the live inputs drive the access so WAIT_STATES=0 can execute on acceptance.
    assign cur_req = (state_q == DMEM_ST_IDLE) ? in_req : req_q;
    assign accept  = (state_q == DMEM_ST_IDLE) && MEM_req_valid;
    assign exec    = (accept && (WAIT_STATES == 0)) || ((state_q == DMEM_ST_WAIT) && (cnt_q == 4'd0));
    assign mis_now = is_misaligned(cur_req.len, cur_req.addr[1:0]);
    assign unused_addr_bits = ^cur_req.addr[31:ADDR_W+2];

    always_comb begin
        sram_be    = 4'b1111;
        sram_wdata = cur_req.wdata;
        case (cur_req.len)
            MEM_LEN_BYTE: begin
                sram_be    = 4'b0001 << cur_req.addr[1:0];
                sram_wdata = {4{cur_req.wdata[7:0]}};
            end
            MEM_LEN_HALF: begin
                sram_be    = cur_req.addr[1] ? 4'b1100 : 4'b0011;
                sram_wdata = {2{cur_req.wdata[15:0]}};
            end
            default: ;
        endcase
        if (!(exec && cur_req.is_store && !mis_now)) sram_be = 4'b0000;
    end

    dmem_sram_bank #(.ADDR_W(ADDR_W)) u_sram (
        .clk   (SYS_clk),
        .be    (sram_be),
        .addr  (cur_req.addr[ADDR_W+1:2]),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        case (state_q)
            DMEM_ST_IDLE: begin
                if (MEM_req_valid) begin
                    req_d = in_req;
                    if (WAIT_STATES > 0) begin
                        state_d = DMEM_ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = DMEM_ST_RESP;
                    end
                end
            end
            DMEM_ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = DMEM_ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DMEM_ST_RESP: begin
                state_d = DMEM_ST_IDLE;
                rdata_d = '0;
                mis_d   = 1'b0;
            end
            default: state_d = DMEM_ST_IDLE;
        endcase
        if (exec) begin
            mis_d   = mis_now;
            rdata_d = (cur_req.is_store || mis_now) ? 32'h0 :
                      load_extract(sram_rdata, cur_req.addr[1:0], cur_req.len, cur_req.sgn);
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q <= DMEM_ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    assign MEM_req_ready  = (state_q == DMEM_ST_IDLE);
    assign MEM_resp_valid = (state_q == DMEM_ST_RESP);
    assign MEM_read_data  = rdata_q;
    assign MEM_misaligned = mis_q;

endmodule
